// File: rtl/ssb_grid_mapper_pkg.sv
// ssb_pkg: shared constants for the SS/PBCH block grid mapper.
//   - Grid geometry: 240 subcarriers x 4 symbols, PSS/SSS span k=56..182,
//     PBCH edges on symbol 2 at k<48 and k>=192.
//   - The 127-entry m-sequences for PSS (x) and SSS (x0, x1) are built once
//     at elaboration and used as read-only lookup tables. Bit i of each
//     vector holds x(i).
//   - FSM state type shared by the top level.
package ssb_pkg;

    localparam int unsigned SSB_NUM_SC  = 240;
    localparam int unsigned SSB_NUM_SYM = 4;
    localparam int unsigned SYNC_LEN    = 127;

    localparam logic [7:0] SYNC_START    = 8'd56;
    localparam logic [7:0] SYNC_END      = 8'(56 + SYNC_LEN - 1);
    localparam logic [7:0] PBCH_LO_END   = 8'd48;
    localparam logic [7:0] PBCH_HI_START = 8'd192;
    localparam logic [7:0] LAST_SC       = 8'(SSB_NUM_SC - 1);
    localparam logic [1:0] LAST_SYM      = 2'(SSB_NUM_SYM - 1);

    localparam logic [8:0] N_ID_1_MAX    = 9'd335;
    localparam logic [8:0] SSS_Q1_BOUND  = 9'd112;
    localparam logic [8:0] SSS_Q2_BOUND  = 9'd224;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // x(i+7) = x(i+tap) ^ x(i), seeded with x(0..6) = init[0..6].
    function automatic logic [126:0] gen_m_seq(input logic [6:0] init,
                                               input logic [6:0] tap);
        logic [126:0] x;
        x = '0;
        x[6:0] = init;
        for (logic [6:0] i = 7'd0; i < 7'd120; i++) begin
            x[i + 7'd7] = x[i + tap] ^ x[i];
        end
        return x;
    endfunction

    // PSS seed [x6..x0] = 1110110; SSS seeds [6..0] = 0000001.
    localparam logic [126:0] PSS_X  = gen_m_seq(7'b1110110, 7'd4);
    localparam logic [126:0] SSS_X0 = gen_m_seq(7'b0000001, 7'd4);
    localparam logic [126:0] SSS_X1 = gen_m_seq(7'b0000001, 7'd1);

endpackage

// File: rtl/ssb_grid_mapper_seq_gen.sv
// ssb_seq_gen: PSS/SSS chip generator.
//   Keeps three mod-127 index counters (PSS, SSS x0, SSS x1). While load_i is
//   high the counters' current value is replaced by the cell-ID dependent
//   offset, so the chip for k=56 comes straight from the offset; every
//   step_i advances the counters past the chip just used.
// Ports:
//   clk_i, reset_i      clock, synchronous active-high reset
//   n_id_1_i, n_id_2_i  latched cell-ID components
//   load_i              next RE is k=56 (sequence start)
//   step_i              a sync RE was consumed this cycle
//   pss_bit_o           1 -> PSS chip is -1
//   sss_bit_o           1 -> SSS chip is -1
module ssb_seq_gen
    import ssb_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [8:0] n_id_1_i,
    input  logic [1:0] n_id_2_i,
    input  logic       load_i,
    input  logic       step_i,
    output logic       pss_bit_o,
    output logic       sss_bit_o
);

    logic [6:0] pss_off;
    logic [6:0] m0_q_part;
    logic [6:0] m0_n2_part;
    logic [6:0] m0;
    logic [6:0] m1;

    logic [6:0] pss_idx_q, s0_idx_q, s1_idx_q;
    logic [6:0] pss_idx, s0_idx, s1_idx;

    function automatic logic [6:0] inc127(input logic [6:0] i);
        return (i == 7'd126) ? 7'd0 : i + 7'd1;
    endfunction

    // Offsets without multipliers: 43*N_id_2 and 5*N_id_2 by table,
    // floor(N_id_1/112) and N_id_1 mod 112 by comparison and subtraction.
    always_comb begin
        case (n_id_2_i)
            2'd1:    begin pss_off = 7'd43; m0_n2_part = 7'd5;  end
            2'd2:    begin pss_off = 7'd86; m0_n2_part = 7'd10; end
            default: begin pss_off = 7'd0;  m0_n2_part = 7'd0;  end
        endcase

        if (n_id_1_i >= SSS_Q2_BOUND) begin
            m0_q_part = 7'd30;
            m1        = 7'(n_id_1_i - SSS_Q2_BOUND);
        end else if (n_id_1_i >= SSS_Q1_BOUND) begin
            m0_q_part = 7'd15;
            m1        = 7'(n_id_1_i - SSS_Q1_BOUND);
        end else begin
            m0_q_part = 7'd0;
            m1        = n_id_1_i[6:0];
        end

        m0 = m0_q_part + m0_n2_part;

        pss_idx = load_i ? pss_off : pss_idx_q;
        s0_idx  = load_i ? m0      : s0_idx_q;
        s1_idx  = load_i ? m1      : s1_idx_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pss_idx_q <= '0;
            s0_idx_q  <= '0;
            s1_idx_q  <= '0;
        end else if (step_i) begin
            pss_idx_q <= inc127(pss_idx);
            s0_idx_q  <= inc127(s0_idx);
            s1_idx_q  <= inc127(s1_idx);
        end
    end

    // (1-2a)(1-2b) is negative exactly when a^b.
    assign pss_bit_o = PSS_X[pss_idx];
    assign sss_bit_o = SSS_X0[s0_idx] ^ SSS_X1[s1_idx];

endmodule

// File: rtl/ssb_grid_mapper.sv
// ssb_grid_mapper: emits the 4x240 REs of one SS/PBCH block in subcarrier
// order. PSS (l=0), SSS (l=2) and zero guards are generated here; PBCH/DMRS
// REs are taken in order from the s_axis_pbch stream.
// Ports:
//   clk_i, reset_i         clock, synchronous active-high reset
//   start_i                request one block (accepted only while idle)
//   N_id_1_i, N_id_2_i     cell ID, captured on accepted start
//   busy_o                 block in progress
//   err_o                  one-cycle pulse for a start with an invalid ID
//   s_axis_pbch_*          upstream PBCH/DMRS RE stream (no buffering)
//   m_axis_out_*           grid RE stream; tuser = symbol l, tlast at k=239
module ssb_grid_mapper
    import ssb_pkg::*;
#(
    parameter int IQ_DW    = 32,
    parameter int SYNC_AMP = 8192
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [8:0]       N_id_1_i,
    input  logic [1:0]       N_id_2_i,
    output logic             busy_o,
    output logic             err_o,
    input  logic [IQ_DW-1:0] s_axis_pbch_tdata,
    input  logic             s_axis_pbch_tvalid,
    output logic             s_axis_pbch_tready,
    output logic [IQ_DW-1:0] m_axis_out_tdata,
    output logic             m_axis_out_tvalid,
    input  logic             m_axis_out_tready,
    output logic             m_axis_out_tlast,
    output logic [1:0]       m_axis_out_tuser
);

    localparam int HALF_W = IQ_DW / 2;
    localparam logic signed [HALF_W-1:0] AMP_POS = HALF_W'(SYNC_AMP);
    localparam logic signed [HALF_W-1:0] AMP_NEG = -AMP_POS;

    // BPSK chip to RE: real = +/-SYNC_AMP, imag = 0.
    function automatic logic [IQ_DW-1:0] sync_re(input logic neg);
        return {{HALF_W{1'b0}}, (neg ? AMP_NEG : AMP_POS)};
    endfunction

    state_e           state_q;
    logic [1:0]       l_q;
    logic [7:0]       k_q;
    logic             all_loaded_q;
    logic [8:0]       n_id_1_q;
    logic [1:0]       n_id_2_q;
    logic             err_q;
    logic [IQ_DW-1:0] tdata_q;
    logic             tvalid_q;
    logic             tlast_q;
    logic [1:0]       tuser_q;

    logic [1:0]       l_d;
    logic [7:0]       k_d;
    logic [IQ_DW-1:0] re_d;
    logic             is_sync;
    logic             is_pbch;
    logic             out_free;
    logic             feed_ok;
    logic             run_load;
    logic             last_hs;
    logic             start_ok;
    logic             pss_bit;
    logic             sss_bit;

    ssb_seq_gen u_seq (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .n_id_1_i  (n_id_1_q),
        .n_id_2_i  (n_id_2_q),
        .load_i    (k_q == SYNC_START),
        .step_i    (run_load && is_sync),
        .pss_bit_o (pss_bit),
        .sss_bit_o (sss_bit)
    );

    // (l_q, k_q) always names the next RE to be placed in the output register.
    always_comb begin
        is_sync  = ((l_q == 2'd0) || (l_q == 2'd2)) &&
                   (k_q >= SYNC_START) && (k_q <= SYNC_END);
        is_pbch  = l_q[0] ||
                   ((l_q == 2'd2) && ((k_q < PBCH_LO_END) || (k_q >= PBCH_HI_START)));
        out_free = !tvalid_q || m_axis_out_tready;
        feed_ok  = (state_q == ST_RUN) && !all_loaded_q && out_free;
        run_load = feed_ok && (!is_pbch || s_axis_pbch_tvalid);
        last_hs  = all_loaded_q && tvalid_q && m_axis_out_tready;
        start_ok = (N_id_2_i != 2'd3) && (N_id_1_i <= N_ID_1_MAX);

        if (is_pbch) begin
            re_d = s_axis_pbch_tdata;
        end else if (is_sync) begin
            re_d = sync_re((l_q == 2'd0) ? pss_bit : sss_bit);
        end else begin
            re_d = '0;
        end

        k_d = (k_q == LAST_SC) ? 8'd0 : k_q + 8'd1;
        l_d = (k_q == LAST_SC) ? l_q + 2'd1 : l_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            l_q          <= '0;
            k_q          <= '0;
            all_loaded_q <= 1'b0;
            n_id_1_q     <= '0;
            n_id_2_q     <= '0;
            err_q        <= 1'b0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            tuser_q      <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        if (start_ok) begin
                            // RE (0,0) is a guard zero, so it is loaded on the
                            // accepting edge and counting resumes at k=1.
                            state_q      <= ST_RUN;
                            n_id_1_q     <= N_id_1_i;
                            n_id_2_q     <= N_id_2_i;
                            l_q          <= 2'd0;
                            k_q          <= 8'd1;
                            all_loaded_q <= 1'b0;
                            tdata_q      <= '0;
                            tvalid_q     <= 1'b1;
                            tlast_q      <= 1'b0;
                            tuser_q      <= 2'd0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (run_load) begin
                        tdata_q  <= re_d;
                        tvalid_q <= 1'b1;
                        tlast_q  <= (k_q == LAST_SC);
                        tuser_q  <= l_q;
                        k_q      <= k_d;
                        l_q      <= l_d;
                        if ((l_q == LAST_SYM) && (k_q == LAST_SC)) begin
                            all_loaded_q <= 1'b1;
                        end
                    end else if (m_axis_out_tready) begin
                        tvalid_q <= 1'b0;
                    end
                    if (last_hs) begin
                        state_q      <= ST_IDLE;
                        all_loaded_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o             = (state_q == ST_RUN);
    assign err_o              = err_q;
    assign s_axis_pbch_tready = feed_ok && is_pbch;
    assign m_axis_out_tdata   = tdata_q;
    assign m_axis_out_tvalid  = tvalid_q;
    assign m_axis_out_tlast   = tlast_q;
    assign m_axis_out_tuser   = tuser_q;

endmodule

// File: doc/ssb_grid_mapper.md
# ssb_grid_mapper

Transmit-side SSB resource-grid generator. On a start pulse it emits the 4×240 frequency-domain REs of one SS/PBCH block in subcarrier order: PSS (symbol 0), SSS (symbol 2) and zero guards are generated internally from N_id_1/N_id_2, and PBCH+DMRS REs are pulled from an upstream stream. Output feeds the IFFT/CP-insertion chain of the test transmitter and mirrors what the receiver's FFT_demod/SSS_detector consume.

## Interface
- IQ_DW, 32: RE width; real in [IQ_DW/2-1:0], imag in [IQ_DW-1:IQ_DW/2], signed.
- SYNC_AMP, 8192: BPSK magnitude for PSS/SSS real part; imag always 0.
- clk_i  in  1  single clock.
- reset_i  in  1  synchronous, active-high.
- start_i  in  1  one-cycle request to emit one SSB.
- N_id_1_i  in  9  0..335, sampled on accepted start.
- N_id_2_i  in  2  0..2, sampled on accepted start.
- busy_o  out  1  high from accepted start until last RE handshaked.
- err_o  out  1  one-cycle pulse on rejected start.
- s_axis_pbch_tdata  in  IQ_DW  pre-modulated PBCH/DMRS RE.
- s_axis_pbch_tvalid  in  1
- s_axis_pbch_tready  out  1
- m_axis_out_tdata  out  IQ_DW  grid RE.
- m_axis_out_tvalid  out  1
- m_axis_out_tready  in  1
- m_axis_out_tlast  out  1  high on k=239 of each symbol.
- m_axis_out_tuser  out  2  symbol index l (0..3).

## Operation
- Grid, k=0..239: l=0: PSS k=56..182, else 0. l=1, l=3: PBCH all 240. l=2: PBCH k=0..47 and 192..239, SSS k=56..182, 0 at 48..55, 183..191. PBCH total 576 REs.
- PSS d(n)=1-2x((n+43·N_id_2) mod 127), n=k-56; x(i+7)=x(i+4)^x(i), [x6..x0]=1110110.
- SSS d(n)=(1-2x0((n+m0) mod 127))(1-2x1((n+m1) mod 127)); m0=15·⌊N_id_1/112⌋+5·N_id_2, m1=N_id_1 mod 112; x0(i+7)=x0(i+4)^x0(i), x1(i+7)=x1(i+1)^x1(i), both init [6..0]=0000001.
- ±1 maps to real ±SYNC_AMP, imag 0. Zero REs are all-zero.
- Sequence indices are mod-127 counters loaded with the offset at k=56 and wrapping 126→0; no multipliers; ⌊N_id_1/112⌋ by comparison against 112/224.
- States: IDLE → RUN (l,k counters) → IDLE. Accepted start in IDLE latches IDs, l=0, k=0.
- Start while busy: ignored, no err_o. Start in IDLE with N_id_2_i=3 or N_id_1_i>335: rejected, err_o=1 next cycle, stays IDLE.
- PBCH REs passed through unmodified, in order.

## Timing
- Reset values: busy_o, err_o, m_axis_out_tvalid, tlast, s_axis_pbch_tready = 0; tdata, tuser = 0; state IDLE.
- Single output register. Loaded when (!tvalid || tready) and the next RE's source is available; generated REs always available, PBCH RE requires s_axis_pbch_tvalid.
- s_axis_pbch_tready = RUN && next RE is PBCH && (!m_axis_out_tvalid || m_axis_out_tready); combinational, no upstream buffering.
- First RE (l=0,k=0) valid the cycle after accepted start; with tready held high, 960 consecutive valid cycles.
- tdata/tuser/tlast stable while tvalid && !tready.
- Missing PBCH data: tvalid drops after current RE drains; resumes same (l,k).
- busy_o falls the cycle after l=3,k=239 handshake; a start in that same cycle is ignored; next start is accepted the following cycle.
- reset_i mid-block: all state to reset values next cycle; partial block discarded.

## Structure
- Package ssb_pkg: 127-bit PSS x, SSS x0, x1 constant vectors (precomputed), SSB_NUM_SC=240, SSB_NUM_SYM=4, PSS/SSS start 56, length 127, PBCH edge 48/192, N_ID_1_MAX=335.
- Sub-module ssb_seq_gen (mod-127 index counters + table lookup, emits d(n) bit); otherwise flat.

## Test plan
- N_id_1=0, N_id_2=0, tready=1, PBCH always valid: l=0 k=56 real=+8192, k=57 real=-8192; l=2 k=56 real=+8192; k=0..55 of l=0 zero; exactly 576 PBCH handshakes; tlast on cycles 240,480,720,960.
- Sweep N_id_2 0..2, N_id_1 ∈ {0,111,112,223,224,335}: PSS/SSS REs bit-exact vs Python model; round-trip through receiver chain detects same N_id_1.
- Random tready/PBCH tvalid (50%): output sequence identical to back-to-back run; no data change while stalled.
- Start with N_id_2=3 and with N_id_1=336: err_o pulses, busy_o stays 0, no output.
- Start pulsed at cycle 500 of a block: ignored; start in cycle after busy_o falls: new block begins.
- reset_i asserted at RE 300: next cycle tvalid=0, busy_o=0; fresh start yields full 960-RE block.
